// File: rtl/err2clrst_pkg.sv
// Shared colour-state codes and the signed error classifier for the
// multi-channel temperature-servo indicator encoder.
package err2clrst_pkg;

    localparam logic [1:0] CLR_LOW   = 2'b00;
    localparam logic [1:0] CLR_SLOW  = 2'b01;
    localparam logic [1:0] CLR_SHIGH = 2'b10;
    localparam logic [1:0] CLR_HIGH  = 2'b11;
    localparam logic [1:0] CLR_RST   = CLR_SHIGH;

    // Operands arrive already sign-extended from W+2 bits; supports W up to 62.
    localparam int unsigned CLS_W = 64;

    // t must be non-negative; a value sitting on a boundary takes the higher code.
    function automatic logic [1:0] clr_classify(input logic signed [CLS_W-1:0] v,
                                                input logic signed [CLS_W-1:0] t);
        logic signed [CLS_W-1:0] neg_t;
        neg_t = -t;
        if (v < neg_t) begin
            return CLR_LOW;
        end else if (v < 0) begin
            return CLR_SLOW;
        end else if (v < t) begin
            return CLR_SHIGH;
        end else begin
            return CLR_HIGH;
        end
    endfunction

endpackage

// File: rtl/err2clrst_ch.sv
// One channel: dead-band classification (stage 1), persistence filter
// (stage 2) and the out-of-range live/sticky bits.
module err2clrst_ch
    import err2clrst_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned HOLD = 4,
    parameter int unsigned CW   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_val,
    input  logic [W-1:0] thr,
    input  logic [W-1:0] hyst_pos,
    input  logic         clr_sticky,
    output logic [1:0]   clrst,
    output logic         oor,
    output logic         oor_next,
    output logic         oor_sticky
);

    localparam int unsigned    XW     = W + 2;
    localparam logic [CW-1:0]  HOLD_C = CW'(HOLD);

    logic signed [XW-1:0]    in_x, thr_x, hyst_x, a_x, b_x;
    logic signed [CLS_W-1:0] a_w, b_w, thr_w;
    logic [1:0]              cls_a, cls_b;

    logic [1:0]    cand_d, cand_q;
    logic [1:0]    clrst_d, clrst_q;
    logic [1:0]    pend_d, pend_q;
    logic [CW-1:0] cnt_d, cnt_q, cnt_inc;
    logic          oor_d, oor_q;
    logic          sticky_d, sticky_q;

    // hyst_pos is already clamped non-negative by the top level.
    assign in_x   = {{2{in_val[W-1]}}, in_val};
    assign thr_x  = thr[W-1] ? '0 : {2'b00, thr};
    assign hyst_x = {2'b00, hyst_pos};
    assign a_x    = in_x - hyst_x;
    assign b_x    = in_x + hyst_x;

    assign a_w   = {{(CLS_W-XW){a_x[XW-1]}}, a_x};
    assign b_w   = {{(CLS_W-XW){b_x[XW-1]}}, b_x};
    assign thr_w = {{(CLS_W-XW){thr_x[XW-1]}}, thr_x};

    assign cls_a   = clr_classify(a_w, thr_w);
    assign cls_b   = clr_classify(b_w, thr_w);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        cand_d  = (cls_a == cls_b) ? cls_a : clrst_q;
        clrst_d = clrst_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (cand_q == clrst_q) begin
            cnt_d = '0;
        end else if (cand_q != pend_q) begin
            pend_d = cand_q;
            cnt_d  = CW'(1);
            if (HOLD == 1) begin
                clrst_d = cand_q;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= HOLD_C) begin
                clrst_d = cand_q;
                cnt_d   = '0;
            end
        end
        oor_d    = (clrst_d == CLR_LOW) || (clrst_d == CLR_HIGH);
        // A fresh out-of-range cycle beats a coincident clear.
        sticky_d = oor_d | (sticky_q & ~clr_sticky);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= CLR_RST;
            clrst_q  <= CLR_RST;
            pend_q   <= CLR_RST;
            cnt_q    <= '0;
            oor_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            clrst_q  <= clrst_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            oor_q    <= oor_d;
            sticky_q <= sticky_d;
        end
    end

    assign clrst      = clrst_q;
    assign oor        = oor_q;
    assign oor_next   = oor_d;
    assign oor_sticky = sticky_q;

endmodule

// File: rtl/err2clrst_mc.sv
// Multi-channel error-to-colour encoder: slices the flat buses, clamps the
// shared dead-band and registers the any-out-of-range summary.
module err2clrst_mc
    import err2clrst_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned W    = 16,
    parameter int unsigned HOLD = 4,
    parameter int unsigned CW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] in_flat,
    input  logic [NCH*W-1:0] thr_flat,
    input  logic [W-1:0]     hyst,
    input  logic             clr_sticky,
    output logic [NCH*2-1:0] clrst_flat,
    output logic [NCH-1:0]   oor,
    output logic [NCH-1:0]   oor_sticky,
    output logic             any_oor
);

    logic [W-1:0]   hyst_pos;
    logic [NCH-1:0] oor_next;
    logic           any_oor_d, any_oor_q;

    assign hyst_pos = hyst[W-1] ? '0 : hyst;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        err2clrst_ch #(
            .W    (W),
            .HOLD (HOLD),
            .CW   (CW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .in_val     (in_flat[k*W +: W]),
            .thr        (thr_flat[k*W +: W]),
            .hyst_pos   (hyst_pos),
            .clr_sticky (clr_sticky),
            .clrst      (clrst_flat[2*k +: 2]),
            .oor        (oor[k]),
            .oor_next   (oor_next[k]),
            .oor_sticky (oor_sticky[k])
        );
    end

    always_comb begin
        any_oor_d = |oor_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_oor_q <= 1'b0;
        end else begin
            any_oor_q <= any_oor_d;
        end
    end

    assign any_oor = any_oor_q;

endmodule
